seg7_scan_mux: RTL
==================

# seg7_scan_mux

Parametrised time-multiplexed seven-segment scanner. It drives NDIG common-anode digits from a packed hex value with per-digit decimal points. Each slot has a programmable dwell and an anti-ghosting blank interval, and the display value is snapshotted once per frame so digits never tear. It sits between the counter/measurement logic and the board display pins.

## Interface
- NDIG, 4, number of digits (2..8)
- PRESCALE, 50000, clock cycles per digit slot (≥ BLANK_CYCLES+1)
- BLANK_CYCLES, 2, cycles at slot start with all digits off (0..PRESCALE-1)

- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- en  in  1  scan enable; low forces the display dark
- value  in  4*NDIG  hex nibbles; nibble i = digit i (digit 0 = rightmost)
- dp  in  NDIG  decimal point request per digit
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low
- seg_dp  out  1  decimal point drive, active-low
- light  out  NDIG  digit enables, active-low, one-cold when lit
- frame_start  out  1  one-cycle pulse when slot 0 begins (snapshot taken)

## Operation
- State: slot counter cnt (0..PRESCALE-1), digit index idx (0..NDIG-1), shadow value/dp registers, run flag.
- cnt increments every cycle while en. At PRESCALE-1, cnt wraps to 0 and idx advances. idx wraps NDIG-1 → 0.
- When idx = 0 and cnt = 0 (including the first cycle after en rises), value/dp are copied into the shadow and frame_start pulses. Input changes mid-frame have no effect until the next frame.
- When cnt < BLANK_CYCLES: light = all ones, seg = 7'h7F, seg_dp = 1.
- Otherwise: light = ~(1<<idx), seg = hex pattern of shadow nibble idx, seg_dp = ~shadow_dp[idx].
- Hex patterns (gfedcba, active-low): 0 = 1000000, 1 = 1111001, 8 = 0000000, F = 0001110. All of 0–F are decoded.
- en low: next cycle cnt = 0, idx = 0, all outputs dark, frame_start = 0. en high again restarts at slot 0 with a fresh snapshot.
- RST (any time, including mid-slot): cnt = 0, idx = 0, shadow = 0, outputs dark. The first frame starts on the first enabled cycle after deassertion.

## Timing
- All outputs are registered. The output state seen on cycle t+1 reflects cnt/idx at cycle t.
- Reset values: seg = 7'h7F, seg_dp = 1, light = all ones, frame_start = 0.
- Frame period = NDIG*PRESCALE cycles.
- Each digit is lit PRESCALE-BLANK_CYCLES cycles per frame. BLANK_CYCLES = 0 means no dark gap.
- frame_start is high for exactly one cycle per frame, aligned with the first blank cycle of slot 0.

## Configuration
- SEG7_LZ_SUPPRESS_EN defined: leading-zero suppression.
  - At snapshot, a mask is computed over digits NDIG-1 down to 1.
  - A digit is suppressed if its nibble is 0, its dp bit is 0, and every higher digit is suppressed.
  - A suppressed slot is fully dark: light all ones, seg off.
  - Digit 0 is never suppressed. Slot timing is unchanged.
- Not defined: no mask logic; every digit is always displayed.

## Structure
- Shared package seg7_pkg holds:
  - the 16 active-low hex segment constants
  - SEG7_OFF (7'h7F)
  - the nibble width constant
- One sub-module, seg7_hex_decode: combinational 4-bit → 7-bit active-low decode, instanced once on the muxed shadow nibble.

## Test plan
- Bench parameters: NDIG = 4, PRESCALE = 8, BLANK_CYCLES = 2.
- Reset then en = 1, value = 16'h1234:
  - light sequence per slot is 1111 ×2 then 1110 ×6, then 1101, 1011, 0111.
  - seg shows 4, 3, 2, 1 respectively.
  - frame_start pulses every 32 cycles.
- value changed 16'h1234 → 16'hABCD during slot 2: the remainder of that frame still shows 1234; the next frame shows D, C, B, A.
- dp = 4'b0100, value = 16'h0008: seg_dp = 0 only during the lit part of slot 2.
- en dropped mid-slot 1: outputs dark next cycle. Re-enable: frame_start pulses, slot 0 starts with a fresh snapshot.
- RST asserted mid-slot 3: outputs go dark immediately (async). After release, scanning restarts at slot 0.
- With SEG7_LZ_SUPPRESS_EN:
  - value = 16'h0050: slots 3 and 2 dark, slots 1 and 0 show 5 and 0.
  - value = 16'h0000: only digit 0 shows 0.
  - dp = 4'b1000 with value = 0: all four digits shown.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scanner.
// Holds the nibble width, the blank pattern and the 16 active-low hex
// segment patterns, bit order {g,f,e,d,c,b,a} (0 = segment lit).
package seg7_pkg;
  localparam int NIB_W = 4;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_OFF   = 7'h7F;
  localparam seg7_t SEG7_HEX_0 = 7'b1000000;
  localparam seg7_t SEG7_HEX_1 = 7'b1111001;
  localparam seg7_t SEG7_HEX_2 = 7'b0100100;
  localparam seg7_t SEG7_HEX_3 = 7'b0110000;
  localparam seg7_t SEG7_HEX_4 = 7'b0011001;
  localparam seg7_t SEG7_HEX_5 = 7'b0010010;
  localparam seg7_t SEG7_HEX_6 = 7'b0000010;
  localparam seg7_t SEG7_HEX_7 = 7'b1111000;
  localparam seg7_t SEG7_HEX_8 = 7'b0000000;
  localparam seg7_t SEG7_HEX_9 = 7'b0010000;
  localparam seg7_t SEG7_HEX_A = 7'b0001000;
  localparam seg7_t SEG7_HEX_B = 7'b0000011;
  localparam seg7_t SEG7_HEX_C = 7'b1000110;
  localparam seg7_t SEG7_HEX_D = 7'b0100001;
  localparam seg7_t SEG7_HEX_E = 7'b0000110;
  localparam seg7_t SEG7_HEX_F = 7'b0001110;
endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: display-side bundle of the scanner.
//   en, value, dp                 : driven by the master (counter logic)
//   seg, seg_dp, light, frame_start: driven by the slave (scanner)
interface seg7_scan_mux_if #(
  parameter int NDIG = 4
);
  logic                en;
  logic [4*NDIG-1:0]   value;
  logic [NDIG-1:0]     dp;
  logic [6:0]          seg;
  logic                seg_dp;
  logic [NDIG-1:0]     light;
  logic                frame_start;

  modport master (output en, value, dp, input seg, seg_dp, light, frame_start);
  modport slave  (input en, value, dp, output seg, seg_dp, light, frame_start);
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational 4-bit hex to 7-segment decode.
//   nib : hex digit in
//   seg : {g,f,e,d,c,b,a}, active-low
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output seg7_t            seg
);
  always_comb begin
    seg = SEG7_OFF;
    case (nib)
      4'h0: seg = SEG7_HEX_0;
      4'h1: seg = SEG7_HEX_1;
      4'h2: seg = SEG7_HEX_2;
      4'h3: seg = SEG7_HEX_3;
      4'h4: seg = SEG7_HEX_4;
      4'h5: seg = SEG7_HEX_5;
      4'h6: seg = SEG7_HEX_6;
      4'h7: seg = SEG7_HEX_7;
      4'h8: seg = SEG7_HEX_8;
      4'h9: seg = SEG7_HEX_9;
      4'hA: seg = SEG7_HEX_A;
      4'hB: seg = SEG7_HEX_B;
      4'hC: seg = SEG7_HEX_C;
      4'hD: seg = SEG7_HEX_D;
      4'hE: seg = SEG7_HEX_E;
      default: seg = SEG7_HEX_F;
    endcase
  end
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed scanner for NDIG common-anode digits.
//   CLK, RST    : clock (rising edge), async active-high reset
//   bus.en      : scan enable, low forces the display dark
//   bus.value   : hex nibbles, nibble i = digit i (digit 0 rightmost)
//   bus.dp      : per-digit decimal point request
//   bus.seg     : {g,f,e,d,c,b,a}, active-low   bus.seg_dp : active-low
//   bus.light   : digit enables, active-low      bus.frame_start : slot-0 pulse
// Each slot is PRESCALE cycles, the first BLANK_CYCLES of which are dark.
// value/dp are snapshotted at the start of slot 0 so a frame never tears.
// Optional: define SEG7_LZ_SUPPRESS_EN for leading-zero suppression.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input logic          CLK,
  input logic          RST,
  seg7_scan_mux_if.slave bus
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  logic [CW-1:0]                 cnt;
  logic [IW-1:0]                 idx;
  logic [NDIG-1:0][NIB_W-1:0]    val_in, shadow, frame_val;
  logic [NDIG-1:0]               dp_sh, frame_dp, frame_sup;
  logic                          take, blank;
  seg7_t                         hex;

  seg7_t                         seg_q;
  logic                          seg_dp_q, fs_q;
  logic [NDIG-1:0]               light_q;

  assign val_in = bus.value;
  assign take   = bus.en && (cnt == '0) && (idx == '0);
  assign blank  = cnt < CNT_BLANK;

  // On the snapshot cycle the shadow is not loaded yet, so bypass the
  // incoming value; this matters when BLANK_CYCLES = 0.
  assign frame_val = take ? val_in : shadow;
  assign frame_dp  = take ? bus.dp : dp_sh;

`ifdef SEG7_LZ_SUPPRESS_EN
  logic [NDIG:0]   chain;
  logic [NDIG-1:0] sup_q;

  // chain[i]: digit i and every digit above it are zero with no dp.
  // Digit 0 is never suppressed.
  always_comb begin
    chain       = '0;
    chain[NDIG] = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--)
      chain[i] = (val_in[i] == '0) && !bus.dp[i] && chain[i+1];
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST)       sup_q <= '0;
    else if (take) sup_q <= chain[NDIG-1:0];

  assign frame_sup = take ? chain[NDIG-1:0] : sup_q;
`else
  assign frame_sup = '0;
`endif

  seg7_hex_decode u_dec (
    .nib (frame_val[idx]),
    .seg (hex)
  );

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt      <= '0;
      idx      <= '0;
      shadow   <= '0;
      dp_sh    <= '0;
      seg_q    <= SEG7_OFF;
      seg_dp_q <= 1'b1;
      light_q  <= '1;
      fs_q     <= 1'b0;
    end else if (!bus.en) begin
      cnt      <= '0;
      idx      <= '0;
      seg_q    <= SEG7_OFF;
      seg_dp_q <= 1'b1;
      light_q  <= '1;
      fs_q     <= 1'b0;
    end else begin
      if (take) begin
        shadow <= val_in;
        dp_sh  <= bus.dp;
      end
      fs_q <= take;

      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (blank || frame_sup[idx]) begin
        seg_q    <= SEG7_OFF;
        seg_dp_q <= 1'b1;
        light_q  <= '1;
      end else begin
        seg_q    <= hex;
        seg_dp_q <= ~frame_dp[idx];
        light_q  <= ~(NDIG'(1) << idx);
      end
    end

  assign bus.seg         = seg_q;
  assign bus.seg_dp      = seg_dp_q;
  assign bus.light       = light_q;
  assign bus.frame_start = fs_q;
endmodule
